// File: rtl/register_file_2r1w_if.sv
// Bus bundle for the 2-read/1-write register file: read addresses/data, write port, debug counter and ack.
interface register_file_2r1w_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 16
);
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [CNT_W-1:0]  wr_count;
  logic              wr_ack;

  modport master (
    output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data,
    input  rd_data1, rd_data2, wr_count, wr_ack
  );

  modport slave (
    input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data,
    output rd_data1, rd_data2, wr_count, wr_ack
  );
endinterface

// File: rtl/register_file_2r1w.sv
// 32 x DATA_W MIPS register file, two async reads, one sync write, r0 hard-wired to zero.
// Optional write-through forwarding on both read ports when RF_WRITE_BYPASS_EN is defined.
module register_file_2r1w #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  register_file_2r1w_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
`ifdef RF_WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0]  wr_count_q, wr_count_d;
  logic              wr_ack_q, wr_ack_d;
  logic              commit_c;
  logic [DATA_W-1:0] rd_data1_c, rd_data2_c;

  // A write commits only when enabled and not aimed at r0; gating on wr_en keeps X addresses harmless.
  always_comb begin
    commit_c   = 1'b0;
    wr_count_d = wr_count_q;
    wr_ack_d   = 1'b0;
    if (bus.wr_en && (bus.wr_addr != '0)) begin
      commit_c   = 1'b1;
      wr_count_d = wr_count_q + CNT_W'(1);
      wr_ack_d   = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_count_q <= '0;
      wr_ack_q   <= 1'b0;
    end else begin
      if (commit_c) begin
        mem_q[bus.wr_addr] <= bus.wr_data;
      end
      wr_count_q <= wr_count_d;
      wr_ack_q   <= wr_ack_d;
    end
  end

  // Read ports: r0 reads zero; forwarding takes the in-flight write data on an address match.
  always_comb begin
    rd_data1_c = '0;
    rd_data2_c = '0;
    if (bus.rd_addr1 != '0) begin
      rd_data1_c = mem_q[bus.rd_addr1];
      if (BYPASS && commit_c && (bus.rd_addr1 == bus.wr_addr)) begin
        rd_data1_c = bus.wr_data;
      end
    end
    if (bus.rd_addr2 != '0) begin
      rd_data2_c = mem_q[bus.rd_addr2];
      if (BYPASS && commit_c && (bus.rd_addr2 == bus.wr_addr)) begin
        rd_data2_c = bus.wr_data;
      end
    end
  end

  assign bus.rd_data1 = rd_data1_c;
  assign bus.rd_data2 = rd_data2_c;
  assign bus.wr_count = wr_count_q;
  assign bus.wr_ack   = wr_ack_q;

endmodule

// File: tb/tb_register_file_2r1w.sv
// Directed bench for register_file_2r1w built with a 4-bit write counter to reach wrap quickly.
module tb_register_file_2r1w;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned CNT_W  = 4;

  logic Clk;
  logic Rst_n;
  int   total;
  int   bad;

  register_file_2r1w_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) rf ();

  register_file_2r1w #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (rf.slave)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    rf.wr_en   = 1'b1;
    rf.wr_addr = a;
    rf.wr_data = d;
    tick();
    rf.wr_en   = 1'b0;
  endtask

  logic [31:0] exp_raw;

  initial begin
    total = 0;
    bad   = 0;
    Rst_n       = 1'b0;
    rf.rd_addr1 = '0;
    rf.rd_addr2 = '0;
    rf.wr_en    = 1'b0;
    rf.wr_addr  = '0;
    rf.wr_data  = '0;
    #12;
    check("reset_count", 32'(rf.wr_count), 32'd0);
    check("reset_ack",   32'(rf.wr_ack),   32'd0);
    check("reset_rd1",   rf.rd_data1,      32'd0);
    Rst_n = 1'b1;

    // T1: async reset clears storage and debug state between edges
    wr(5'd5, 32'hDEADBEEF);
    rf.rd_addr1 = 5'd5;
    #1;
    check("t1_pre_rd1",   rf.rd_data1,      32'hDEADBEEF);
    check("t1_pre_count", 32'(rf.wr_count), 32'd1);
    Rst_n = 1'b0;
    #1;
    check("t1_rst_rd1",   rf.rd_data1,      32'd0);
    check("t1_rst_count", 32'(rf.wr_count), 32'd0);
    check("t1_rst_ack",   32'(rf.wr_ack),   32'd0);
    #1;
    Rst_n = 1'b1;

    // T2: basic write/read with ack pulse
    wr(5'd3, 32'h12345678);
    check("t2_ack1", 32'(rf.wr_ack), 32'd1);
    tick();
    check("t2_ack_idle", 32'(rf.wr_ack), 32'd0);
    wr(5'd31, 32'hFFFFFFFF);
    check("t2_ack2",  32'(rf.wr_ack),   32'd1);
    check("t2_count", 32'(rf.wr_count), 32'd2);
    rf.rd_addr1 = 5'd3;
    rf.rd_addr2 = 5'd31;
    #1;
    check("t2_rd1", rf.rd_data1, 32'h12345678);
    check("t2_rd2", rf.rd_data2, 32'hFFFFFFFF);

    // T3: writes to r0 are dropped, uncounted, unacked
    wr(5'd0, 32'hAAAA5555);
    rf.rd_addr1 = 5'd0;
    #1;
    check("t3_rd1",   rf.rd_data1,      32'd0);
    check("t3_count", 32'(rf.wr_count), 32'd2);
    check("t3_ack",   32'(rf.wr_ack),   32'd0);

    // T4: same-cycle read-after-write
    wr(5'd7, 32'h1);
    rf.wr_en    = 1'b1;
    rf.wr_addr  = 5'd7;
    rf.wr_data  = 32'h2;
    rf.rd_addr1 = 5'd7;
    rf.rd_addr2 = 5'd3;
    #1;
`ifdef RF_WRITE_BYPASS_EN
    exp_raw = 32'h2;
`else
    exp_raw = 32'h1;
`endif
    check("t4_before_edge", rf.rd_data1, exp_raw);
    check("t4_port2_indep", rf.rd_data2, 32'h12345678);
    tick();
    rf.wr_en = 1'b0;
    check("t4_after_edge", rf.rd_data1,      32'h2);
    check("t4_count",      32'(rf.wr_count), 32'd4);

    // Disabled write with an unknown address must not touch storage
    rf.wr_addr  = 'x;
    rf.wr_data  = 32'h0BAD0BAD;
    rf.rd_addr2 = 5'd3;
    tick();
    check("x_addr_reg3",  rf.rd_data2,      32'h12345678);
    check("x_addr_count", 32'(rf.wr_count), 32'd4);

    // T5: counter wraps after 16 back-to-back commits
    Rst_n = 1'b0;
    #1;
    Rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr(5'(i + 1), 32'(i));
    end
    check("t5_wrap0", 32'(rf.wr_count), 32'd0);
    check("t5_ack",   32'(rf.wr_ack),   32'd1);
    wr(5'd20, 32'hC0FFEE);
    check("t5_wrap1", 32'(rf.wr_count), 32'd1);
    rf.rd_addr1 = 5'd16;
    #1;
    check("t5_reg16", rf.rd_data1, 32'd15);

    // T6: dual-port same address, then reset overlapping an active write
    rf.rd_addr1 = 5'd9;
    rf.rd_addr2 = 5'd9;
    #1;
    check("t6_rd1", rf.rd_data1, 32'd8);
    check("t6_rd2", rf.rd_data2, 32'd8);
    rf.wr_en   = 1'b1;
    rf.wr_addr = 5'd9;
    rf.wr_data = 32'h55;
    Rst_n      = 1'b0;
    tick();
    check("t6_in_rst", rf.rd_data1, 32'd0);
    #2;
    Rst_n = 1'b1;
    #1;
    check("t6_released_no_edge", rf.rd_data1,      32'd0);
    check("t6_released_count",   32'(rf.wr_count), 32'd0);
    tick();
    rf.wr_en = 1'b0;
    check("t6_first_commit", rf.rd_data1,      32'h55);
    check("t6_commit_count", 32'(rf.wr_count), 32'd1);
    check("t6_commit_ack",   32'(rf.wr_ack),   32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
